io_out_fifo: RTL and testbench

- Output-port stage directly downstream of the load_store processor.
- Captures each 16-bit value the processor writes to its output port (write_out) and buffers it in a small FIFO.
- Presents the buffered values to an external consumer over a valid/ready handshake.
- Returns a full flag so the processor can stall its output instruction instead of losing data.

---
 rtl/io_out_fifo.sv | 84 ++++++++
 tb/tb_io_out_fifo.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/io_out_fifo.sv
// Output-port FIFO between the load_store processor's write_out and an external valid/ready consumer.
// Optional dropped-write counter enabled by defining IO_OUT_FIFO_OVF_CNT_EN.
module io_out_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  output logic             full,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      level,
  output logic [7:0]       ovf_count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push;
  logic             pop;

  // full is taken from the registered count, so a pop cannot free a slot for a same-cycle write
  assign full      = (count_reg == (AW+1)'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign level     = count_reg;
  assign out_data  = out_valid ? mem[rd_ptr_reg] : '0;

  assign push = wr_en & ~full;
  assign pop  = out_valid & out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clock) begin
        if (!rst && push && (wr_ptr_reg == AW'(gi))) begin
          mem[gi] <= wr_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifdef IO_OUT_FIFO_OVF_CNT_EN
  logic [7:0] ovf_reg;

  // Saturating count of writes dropped because the FIFO was full
  always_ff @(posedge clock) begin
    if (rst) begin
      ovf_reg <= '0;
    end else if (wr_en && full && (ovf_reg != 8'hFF)) begin
      ovf_reg <= ovf_reg + 8'd1;
    end
  end

  assign ovf_count = ovf_reg;
`else
  assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_io_out_fifo.sv
// Self-checking bench for io_out_fifo: directed scenarios plus random traffic against a queue model.
module tb_io_out_fifo;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clock = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] wr_data = '0;
  logic             wr_en = 1'b0;
  logic             full;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [AW:0]      level;
  logic [7:0]       ovf_count;

  int checks = 0;
  int failures = 0;

  // Reference model: the FIFO contents as a plain queue plus the drop counter
  logic [WIDTH-1:0] model_q[$];
  int               model_ovf = 0;
  int               cyc = 0;

  io_out_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clock(clock),
    .rst(rst),
    .wr_data(wr_data),
    .wr_en(wr_en),
    .full(full),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level(level),
    .ovf_count(ovf_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic [WIDTH-1:0] exp_data;
    exp_data = (model_q.size() != 0) ? model_q[0] : '0;
    check("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
    check("full", 32'(full), 32'(model_q.size() == DEPTH));
    check("level", 32'(level), 32'(model_q.size()));
    check("out_data", 32'(out_data), 32'(exp_data));
`ifdef IO_OUT_FIFO_OVF_CNT_EN
    check("ovf_count", 32'(ovf_count), 32'(model_ovf));
`else
    check("ovf_count", 32'(ovf_count), 32'd0);
`endif
  endtask

  // Apply one cycle of stimulus, advance the model from its pre-edge state, then check after the edge
  task automatic step(input logic r, input logic we, input logic [WIDTH-1:0] wd, input logic rdy);
    logic was_full;
    logic do_pop;
    logic do_push;
    rst = r;
    wr_en = we;
    wr_data = wd;
    out_ready = rdy;
    was_full = (model_q.size() == DEPTH);
    do_pop = (model_q.size() != 0) && rdy;
    do_push = we && !was_full;
    @(posedge clock);
    #1;
    cyc++;
    if (r) begin
      model_q.delete();
      model_ovf = 0;
    end else begin
      if (we && was_full && model_ovf < 255) model_ovf++;
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(wd);
    end
    $display("cycle=%0d rst=%0b wr_en=%0b wr_data=0x%04h out_ready=%0b -> level=%0d out_valid=%0b out_data=0x%04h full=%0b ovf=%0d",
             cyc, r, we, wd, rdy, level, out_valid, out_data, full, ovf_count);
    check_outputs();
  endtask

  initial begin
    logic [WIDTH-1:0] pats[5];
    int next_val;
    pats[0] = 16'h1111; pats[1] = 16'h2222; pats[2] = 16'h3333;
    pats[3] = 16'h4444; pats[4] = 16'h5555;

    // Reset for 5 cycles
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);

    // Single write, held off, then popped
    step(1'b0, 1'b1, 16'h000B, 1'b0);
    check("single_data", 32'(out_data), 32'h000B);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    check("single_empty", 32'(level), 32'd0);

    // Fill with 5 pushes, 5th dropped, then drain
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, pats[i], 1'b0);
      if (i == 3) check("fill_full", 32'(full), 32'd1);
    end
    check("fill_level", 32'(level), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("drain_order", 32'(out_data), 32'(pats[i]));
      step(1'b0, 1'b0, '0, 1'b1);
    end
    check("drain_empty", 32'(out_valid), 32'd0);

    // Simultaneous push/pop at level 2
    step(1'b0, 1'b1, 16'hAAAA, 1'b0);
    step(1'b0, 1'b1, 16'hBBBB, 1'b0);
    step(1'b0, 1'b1, 16'hCCCC, 1'b1);
    check("pp_level", 32'(level), 32'd2);
    check("pp_head", 32'(out_data), 32'hBBBB);
    step(1'b0, 1'b0, '0, 1'b1);
    check("pp_last", 32'(out_data), 32'hCCCC);
    step(1'b0, 1'b0, '0, 1'b1);

    // Wrap-around: pushes 1..10, popping whenever level reaches 2 keeps level <= 3
    next_val = 1;
    while (next_val <= 10 || model_q.size() != 0) begin
      step(1'b0, next_val <= 10, 16'(next_val), model_q.size() >= 2 || next_val > 10);
      check("wrap_bound", 32'(level <= 3), 32'd1);
      if (next_val <= 10) next_val++;
    end

    // Reset mid-operation with a concurrent write
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h7000 + 16'(i), 1'b0);
    step(1'b1, 1'b1, 16'hDEAD, 1'b0);
    check("midrst_level", 32'(level), 32'd0);
    step(1'b0, 1'b0, '0, 1'b1);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           16'($urandom()), ($urandom_range(0, 2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
